// File: rtl/sfq_ndro_readout.sv
// sfq_ndro_readout
//
// Clocked readout stage for the edge-encoded output of an NDRO cell. Every
// transition on sfq_in is one SFQ pulse. The line is synchronized, turned into
// a one-cycle pulse_det, and accumulated per readout slot. A slot that saw a
// pulse contributes a 1. WIDTH slot bits are packed MSB-first into a word that
// is offered on a valid/ready handshake. Protocol and timing faults are kept
// as sticky flags.
//
// Ports:
//   clk         system sampling clock, rising edge
//   reset       asynchronous active-low reset, clears all state
//   sfq_in      edge-encoded pulse line from the NDRO cell
//   slot        one-cycle strobe closing the current readout slot
//   err_clr     synchronous clear of the sticky error flags
//   data_out    completed word, first slot in MSB
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts the word when high together with data_valid
//   err_multi   sticky: two or more pulses seen in one slot
//   err_overrun sticky: a word completed while the output register was full
//   err_x       sticky, simulation only: X/Z sampled on sfq_in

module sfq_ndro_readout #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sfq_in,
    input  logic             slot,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             err_multi,
    output logic             err_overrun,
    output logic             err_x
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    // State
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_q, arm_d;
    logic                   hit_q, hit_d;
    logic                   multi_q, multi_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_multi_q, err_multi_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   err_x_q, err_x_d;

    // Combinational helpers
    logic             sfq_bad;
    logic             armed;
    logic             pulse_det;
    logic             slot_bit;
    logic             word_done;
    logic             load;
    logic             multi_evt;
    logic             overrun_evt;
    logic [WIDTH-1:0] shreg_next;

    always_comb begin
        // Only a four-state simulator can see X/Z here; in hardware this is 0.
        sfq_bad = (sfq_in !== 1'b0) && (sfq_in !== 1'b1);

        // First stage holds its value on X/Z so no pulse is ever derived from it.
        sync_d = {sync_q[SYNC_STAGES-2:0], (sfq_bad ? sync_q[0] : sfq_in)};

        // pulse_det is masked while the chain refills after reset; prev keeps
        // tracking, so a static high level at release never reads as a pulse.
        armed = (arm_q == ARM_DONE);
        arm_d = armed ? arm_q : arm_q + ARM_W'(1);

        pulse_det  = (sync_q[SYNC_STAGES-1] ^ prev_q) & armed;

        // A pulse arriving in the closing cycle belongs to the closing slot.
        slot_bit   = hit_q | pulse_det;
        shreg_next = {shreg_q[WIDTH-2:0], slot_bit};

        word_done  = slot && (cnt_q == CNT_LAST);
        load       = word_done && (!valid_q || data_ready);

        multi_evt   = slot && (multi_q || (hit_q && pulse_det));
        overrun_evt = word_done && !load;
    end

    always_comb begin
        hit_d   = hit_q;
        multi_d = multi_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        if (slot) begin
            // Slot close: no carry-over of hit/multi into the next slot.
            hit_d   = 1'b0;
            multi_d = 1'b0;
            if (word_done) begin
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = shreg_next;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            hit_d   = hit_q | pulse_det;
            multi_d = multi_q | (hit_q & pulse_det);
        end
    end

    always_comb begin
        data_d  = load ? shreg_next : data_q;
        // A consumed word drops valid unless the same edge loads a new one.
        valid_d = load || (valid_q && !data_ready);

        // Clear loses to a fault detected in the same cycle.
        err_multi_d   = (err_multi_q   && !err_clr) || multi_evt;
        err_overrun_d = (err_overrun_q && !err_clr) || overrun_evt;
        err_x_d       = (err_x_q       && !err_clr) || sfq_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '0;
            prev_q        <= 1'b0;
            arm_q         <= '0;
            hit_q         <= 1'b0;
            multi_q       <= 1'b0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            err_multi_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_x_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= sync_q[SYNC_STAGES-1];
            arm_q         <= arm_d;
            hit_q         <= hit_d;
            multi_q       <= multi_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            err_multi_q   <= err_multi_d;
            err_overrun_q <= err_overrun_d;
            err_x_q       <= err_x_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign err_multi   = err_multi_q;
    assign err_overrun = err_overrun_q;
    assign err_x       = err_x_q;

endmodule
